// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, counting modes
// and CTRL field positions.
package timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_RELOAD   = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_HOLD_ALT = 2'b11
    } mode_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;
    localparam int unsigned CTRL_W       = 4;

    function automatic logic mode_counts(input mode_e m);
        return (m == MODE_ONESHOT) || (m == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PRESET registers, count, and a sticky
// pending flag where an expiry outranks a same-cycle W1C clear.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_ctrl,
    input  logic              wr_preset,
    input  logic              clr_pend,
    input  logic [31:0]       wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  preset,
    output logic [WIDTH-1:0]  count,
    output logic              pending
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              pending_q, pending_d;
    mode_e             mode;
    logic              unused_wdata;

    assign mode         = mode_e'(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign unused_wdata = ^wdata;

    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q & ~clr_pend;
        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
            if (wdata[CTRL_EN]) begin
                count_d = preset_q;
            end
        end else if (wr_preset) begin
            preset_d = wdata[WIDTH-1:0];
            count_d  = wdata[WIDTH-1:0];
        end else if (ctrl_q[CTRL_EN] && mode_counts(mode)) begin
            // Expiry is evaluated after the clear so it wins a same-cycle W1C.
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else if (mode == MODE_ONESHOT) begin
                ctrl_d[CTRL_EN] = 1'b0;
                pending_d       = 1'b1;
            end else begin
                count_d   = preset_q;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign preset  = preset_q;
    assign count   = count_q;
    assign pending = pending_q;

endmodule

// File: rtl/multi_timer.sv
// NCH-channel timer peripheral: address decode onto timer_channel instances,
// combinational readback mux and masked IRQ reduction.
module multi_timer
    import timer_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [7:2]     addr,
    input  logic           WE,
    input  logic [31:0]    Din,
    output logic [31:0]    Dout,
    output logic           IRQ,
    output logic [NCH-1:0] irq_vec
);

    logic [3:0]            chan;
    reg_e                  reg_sel;
    logic [NCH-1:0][31:0]  rd_word;

    assign chan    = addr[7:4];
    assign reg_sel = reg_e'(addr[3:2]);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic              sel;
        logic              wr_ctrl, wr_preset, clr_pend;
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH-1:0]  preset, count;
        logic              pending;
        logic [31:0]       word;

        assign sel       = (chan == 4'(i));
        assign wr_ctrl   = WE && sel && (reg_sel == REG_CTRL);
        assign wr_preset = WE && sel && (reg_sel == REG_PRESET);
        assign clr_pend  = WE && sel && (reg_sel == REG_STATUS) && Din[0];

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_ctrl  (wr_ctrl),
            .wr_preset(wr_preset),
            .clr_pend (clr_pend),
            .wdata    (Din),
            .ctrl     (ctrl),
            .preset   (preset),
            .count    (count),
            .pending  (pending)
        );

        always_comb begin
            word = '0;
            case (reg_sel)
                REG_CTRL:   word[CTRL_W-1:0] = ctrl;
                REG_PRESET: word[WIDTH-1:0]  = preset;
                REG_COUNT:  word[WIDTH-1:0]  = count;
                REG_STATUS: word[0]          = pending;
                default:    word             = '0;
            endcase
        end

        // Non-selected channels contribute zero so the top can OR-combine.
        assign rd_word[i] = sel ? word : '0;
        assign irq_vec[i] = pending & ctrl[CTRL_IM];
    end

    always_comb begin
        Dout = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            Dout = Dout | rd_word[c];
        end
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized runs
// against an arithmetic (time-since-arm) reference model.
module tb_multi_timer;

    localparam int R_CTRL = 0, R_PRESET = 1, R_COUNT = 2, R_STATUS = 3;

    logic        clk;
    logic        reset_n;
    logic [7:2]  addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic [1:0]  irq_vec;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    multi_timer #(
        .NCH  (2),
        .WIDTH(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .IRQ    (IRQ),
        .irq_vec(irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        addr = {4'(ch), 2'(r)};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = 32'hDEAD_BEEF;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        WE   = 1'b0;
        addr = {4'(ch), 2'(r)};
        #1;
        v = Dout;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        WE      = 1'b0;
        Din     = '1;
        addr    = '0;
        #1;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            #1;
            n_tests++; if (Dout !== 32'd0) begin n_fail++; $display("FAIL reset_dout addr=%0d got=%h exp=0", a, Dout); end
        end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
        n_tests++; if (irq_vec !== 2'b00) begin n_fail++; $display("FAIL reset_irqvec got=%b exp=00", irq_vec); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(0, R_PRESET, 32'd3);
        wr(0, R_CTRL, 32'h9);
        for (int k = 0; k < 4; k++) begin
            rd(0, R_COUNT, v);
            n_tests++; if (v !== 32'(3 - k)) begin n_fail++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, v, 3 - k); end
            rd(0, R_STATUS, v);
            n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_early_pend k=%0d got=%h exp=0", k, v); end
            tick();
        end
        rd(0, R_STATUS, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL oneshot_pend got=%h exp=1", v); end
        rd(0, R_CTRL, v);
        n_tests++; if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_clear got=%h exp=8", v); end
        repeat (3) tick();
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_stays0 got=%h exp=0", v); end
        n_tests++; if (IRQ !== 1'b1 || irq_vec !== 2'b01) begin n_fail++; $display("FAIL oneshot_irq got=%b/%b exp=1/01", IRQ, irq_vec); end
        wr(0, R_STATUS, 32'd1);
        #1;
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_w1c_irq got=%b exp=0", IRQ); end
        rd(0, R_STATUS, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL oneshot_w1c got=%h exp=0", v); end
    endtask

    task automatic test_reload();
        logic [31:0] v;
        int          exp_c [7] = '{2, 1, 0, 2, 1, 0, 2};
        int          exp_p [7] = '{0, 0, 0, 1, 0, 0, 1};
        wr(0, R_PRESET, 32'd2);
        wr(0, R_CTRL, 32'hB);
        for (int k = 0; k < 7; k++) begin
            rd(0, R_COUNT, v);
            n_tests++; if (v !== 32'(exp_c[k])) begin n_fail++; $display("FAIL reload_count k=%0d got=%h exp=%h", k, v, exp_c[k]); end
            rd(0, R_STATUS, v);
            n_tests++; if (v !== 32'(exp_p[k])) begin n_fail++; $display("FAIL reload_pend k=%0d got=%h exp=%h", k, v, exp_p[k]); end
            if (k == 3) wr(0, R_STATUS, 32'd1);
            else        tick();
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        wr(0, R_CTRL, 32'h0);
        wr(0, R_STATUS, 32'd1);
        wr(0, R_PRESET, 32'd2);
        wr(0, R_CTRL, 32'hB);
        tick();
        tick();
        wr(0, R_STATUS, 32'd1);
        rd(0, R_STATUS, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL simul_w1c_vs_expiry got=%h exp=1", v); end
        wr(1, R_PRESET, 32'd20);
        wr(1, R_CTRL, 32'h3);
        wr(0, R_PRESET, 32'd5);
        wr(0, R_PRESET, 32'd7);
        wr(1, R_COUNT, 32'd99);
        wr(1, R_STATUS, 32'd1);
        rd(1, R_COUNT, v);
        n_tests++; if (v !== 32'd16) begin n_fail++; $display("FAIL simul_ch1_counting got=%h exp=10", v); end
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'd5) begin n_fail++; $display("FAIL simul_ch0_count got=%h exp=5", v); end
        rd(0, R_PRESET, v);
        n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL simul_ch0_preset got=%h exp=7", v); end
    endtask

    task automatic test_mask_unmapped();
        logic [31:0] v;
        wr(0, R_CTRL, 32'h0);
        wr(0, R_STATUS, 32'd1);
        wr(1, R_CTRL, 32'h0);
        wr(1, R_STATUS, 32'd1);
        wr(1, R_PRESET, 32'd1);
        wr(1, R_CTRL, 32'h1);
        tick();
        tick();
        rd(1, R_STATUS, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL mask_pend got=%h exp=1", v); end
        n_tests++; if (IRQ !== 1'b0 || irq_vec !== 2'b00) begin n_fail++; $display("FAIL mask_irq got=%b/%b exp=0/00", IRQ, irq_vec); end
        wr(1, R_CTRL, 32'h8);
        #1;
        n_tests++; if (IRQ !== 1'b1 || irq_vec !== 2'b10) begin n_fail++; $display("FAIL unmask_irq got=%b/%b exp=1/10", IRQ, irq_vec); end
        wr(2, R_CTRL, 32'hF);
        wr(2, R_PRESET, 32'h55);
        wr(2, R_STATUS, 32'h1);
        for (int r = 0; r < 4; r++) begin
            rd(2, r, v);
            n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_read reg=%0d got=%h exp=0", r, v); end
        end
        rd(15, R_CTRL, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_ch15 got=%h exp=0", v); end
        rd(0, R_CTRL, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_alias_ctrl got=%h exp=0", v); end
        rd(0, R_PRESET, v);
        n_tests++; if (v !== 32'd7) begin n_fail++; $display("FAIL unmapped_alias_preset got=%h exp=7", v); end
        rd(1, R_STATUS, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL unmapped_alias_status got=%h exp=1", v); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(0, R_PRESET, 32'd10);
        wr(0, R_CTRL, 32'h9);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (IRQ !== 1'b0 || irq_vec !== 2'b00) begin n_fail++; $display("FAIL areset_irq got=%b/%b exp=0/00", IRQ, irq_vec); end
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL areset_count got=%h exp=0", v); end
        rd(1, R_STATUS, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL areset_pend got=%h exp=0", v); end
        rd(1, R_CTRL, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL areset_ctrl got=%h exp=0", v); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        rd(0, R_CTRL, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL postreset_ctrl got=%h exp=0", v); end
        wr(0, R_PRESET, 32'd4);
        tick();
        tick();
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'd4) begin n_fail++; $display("FAIL postreset_idle got=%h exp=4", v); end
        wr(0, R_CTRL, 32'h1);
        tick();
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL postreset_start got=%h exp=3", v); end
    endtask

    task automatic test_width();
        logic [31:0] v;
        wr(0, R_CTRL, 32'h0);
        wr(0, R_PRESET, 32'hFFFF_FFFF);
        rd(0, R_PRESET, v);
        n_tests++; if (v !== 32'h0000_00FF) begin n_fail++; $display("FAIL width_preset got=%h exp=000000ff", v); end
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'h0000_00FF) begin n_fail++; $display("FAIL width_count got=%h exp=000000ff", v); end
        wr(0, R_CTRL, 32'hFFFF_FFF1);
        rd(0, R_CTRL, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL width_ctrl got=%h exp=1", v); end
        tick();
        rd(0, R_COUNT, v);
        n_tests++; if (v !== 32'h0000_00FE) begin n_fail++; $display("FAIL width_dec got=%h exp=000000fe", v); end
        wr(0, R_CTRL, 32'h0);
        wr(0, R_STATUS, 32'd1);
        wr(0, R_PRESET, 32'd0);
        wr(0, R_CTRL, 32'h3);
        rd(0, R_STATUS, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL p0_reload_arm got=%h exp=0", v); end
        for (int i = 0; i < 4; i++) begin
            wr(0, R_STATUS, 32'd1);
            rd(0, R_STATUS, v);
            n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL p0_reload_every i=%0d got=%h exp=1", i, v); end
        end
        wr(0, R_CTRL, 32'h0);
        wr(0, R_STATUS, 32'd1);
        wr(0, R_CTRL, 32'h1);
        tick();
        rd(0, R_STATUS, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL p0_oneshot_pend got=%h exp=1", v); end
        rd(0, R_CTRL, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL p0_oneshot_en got=%h exp=0", v); end
    endtask

    // Model: after arming at edge `arm`, k edges later the count is P-k (one-shot,
    // floored at 0) or P-(k mod (P+1)) (reload); expiries fall on arm+n*(P+1).
    task automatic test_random();
        logic [31:0] v;
        int ch, p, mode, im, steps, k, exp_cnt, exp_en, exp_pend, has_le, le;
        int unsigned arm, clr_edge;
        logic [1:0] exp_vec;
        for (int it = 0; it < 30; it++) begin
            ch    = int'($urandom_range(0, 1));
            p     = int'($urandom_range(0, 12));
            mode  = int'($urandom_range(0, 1));
            im    = int'($urandom_range(0, 1));
            steps = int'($urandom_range(1, 3 * p + 6));
            wr(0, R_CTRL, 32'h0);
            wr(1, R_CTRL, 32'h0);
            wr(0, R_STATUS, 32'd1);
            wr(1, R_STATUS, 32'd1);
            clr_edge = cyc;
            wr(ch, R_PRESET, 32'(p));
            wr(ch, R_CTRL, 32'(im * 8 + mode * 2 + 1));
            arm = cyc;
            for (int s = 0; s < steps; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr(ch, R_STATUS, 32'd1);
                    clr_edge = cyc;
                end else begin
                    tick();
                end
                k = int'(cyc - arm);
                if (mode == 0) begin
                    has_le  = (k >= p + 1) ? 1 : 0;
                    le      = int'(arm) + p + 1;
                    exp_cnt = (k >= p) ? 0 : p - k;
                    exp_en  = has_le ? 0 : 1;
                end else begin
                    has_le  = (k >= p + 1) ? 1 : 0;
                    le      = int'(arm) + (k / (p + 1)) * (p + 1);
                    exp_cnt = p - (k % (p + 1));
                    exp_en  = 1;
                end
                exp_pend = (has_le != 0 && le >= int'(clr_edge)) ? 1 : 0;
                exp_vec  = '0;
                exp_vec[ch] = (exp_pend != 0 && im != 0);
                rd(ch, R_COUNT, v);
                n_tests++; if (v !== 32'(exp_cnt)) begin n_fail++; $display("FAIL rand_count it=%0d k=%0d got=%h exp=%h", it, k, v, exp_cnt); end
                rd(ch, R_STATUS, v);
                n_tests++; if (v !== 32'(exp_pend)) begin n_fail++; $display("FAIL rand_pend it=%0d k=%0d got=%h exp=%h", it, k, v, exp_pend); end
                rd(ch, R_CTRL, v);
                n_tests++; if (v !== 32'(im * 8 + mode * 2 + exp_en)) begin n_fail++; $display("FAIL rand_ctrl it=%0d k=%0d got=%h exp=%h", it, k, v, im * 8 + mode * 2 + exp_en); end
                n_tests++; if (irq_vec !== exp_vec || IRQ !== (|exp_vec)) begin n_fail++; $display("FAIL rand_irq it=%0d k=%0d got=%b/%b exp=%b/%b", it, k, IRQ, irq_vec, |exp_vec, exp_vec); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_simultaneous();
        test_mask_unmapped();
        test_async_reset();
        test_width();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
